// File: rtl/bram_row_gather_pkg.sv
// row_gather_pkg: shared FSM state type, latency bound and signed max helper for bram_row_gather
package row_gather_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;
    localparam int MAX_READ_LATENCY = 4;
    function automatic logic signed [31:0] smax(input logic signed [31:0] a, input logic signed [31:0] b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/bram_row_gather_if.sv
// bram_row_gather_if: request, BRAM read port and row-output handshake bundle for bram_row_gather
// master: the gatherer (drives busy, bram_en/bram_addr, o_data/o_valid/done/o_max)
// slave:  the environment (drives start/row_idx, bram_rdata, o_ready)
interface bram_row_gather_if
    import row_gather_pkg::*;
#(
    parameter int BIT_WIDTH    = 16,
    parameter int N            = 32,
    parameter int LANES        = 1,
    parameter int ROW_COUNT    = 32,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = $clog2(ROW_COUNT * (N / LANES))
);
    logic start;
    logic [$clog2(ROW_COUNT)-1:0] row_idx;
    logic busy;
    logic bram_en;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [LANES*BIT_WIDTH-1:0] bram_rdata;
    logic signed [BIT_WIDTH-1:0] o_data [N];
    logic o_valid;
    logic o_ready;
    logic done;
    logic signed [BIT_WIDTH-1:0] o_max;
    modport master (
        input start, row_idx, bram_rdata, o_ready,
        output busy, bram_en, bram_addr, o_data, o_valid, done, o_max
    );
    modport slave (
        output start, row_idx, bram_rdata, o_ready,
        input busy, bram_en, bram_addr, o_data, o_valid, done, o_max
    );
endinterface

// File: rtl/bram_row_gather_lat_pipe.sv
// row_gather_lat_pipe: delay line carrying {valid, word index} alongside each issued BRAM read
// Ports: clk, rst (async, active-high); v_i/idx_i tag entering with each address;
//        v_o/idx_o the same tag DEPTH cycles later, aligned with its read data.
module row_gather_lat_pipe
    import row_gather_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int IW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v_i,
    input  logic [IW-1:0] idx_i,
    output logic          v_o,
    output logic [IW-1:0] idx_o
);
    localparam int PW = DEPTH * IW;
    logic [DEPTH-1:0] v_q;
    logic [PW-1:0] idx_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v_q <= '0;
            idx_q <= '0;
        end else begin
            v_q <= DEPTH'({v_q, v_i});
            idx_q <= PW'({idx_q, idx_i});
        end
    assign v_o = v_q[DEPTH-1];
    assign idx_o = idx_q[PW-1 -: IW];
endmodule

// File: rtl/bram_row_gather.sv
// bram_row_gather: gathers one run-time selected matrix row from BRAM into a parallel register vector
// Ports: clk, rst (async, active-high); bus (bram_row_gather_if.master) carrying start/row_idx/busy,
//        the bram_en/bram_addr/bram_rdata read port and the o_data/o_valid/o_ready/done/o_max output.
// Build option: define ROW_GATHER_MAX_EN to track the running signed row maximum on o_max.
module bram_row_gather
    import row_gather_pkg::*;
#(
    parameter int BIT_WIDTH    = 16,
    parameter int N            = 32,
    parameter int LANES        = 1,
    parameter int ROW_COUNT    = 32,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = $clog2(ROW_COUNT * (N / LANES))
) (
    input logic clk,
    input logic rst,
    bram_row_gather_if.master bus
);
    localparam int WORDS = N / LANES;
    localparam int RW = $clog2(ROW_COUNT);
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam int CW = $clog2(WORDS + MAX_READ_LATENCY) + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROW_COUNT - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(READ_LATENCY - 1);

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic accept, issue, cap_v;
    logic [IW-1:0] cap_idx;
    logic signed [BIT_WIDTH-1:0] lane [LANES];

    assign accept = state_q == IDLE && bus.start;
    assign issue = state_q == ISSUE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            row_q <= row_d;
        end

    // cnt_q walks the word index in ISSUE and the latency wait in DRAIN
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        row_d = row_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = ISSUE;
                cnt_d = '0;
                row_d = bus.row_idx > LAST_ROW ? LAST_ROW : bus.row_idx;
            end
            ISSUE: begin
                state_d = cnt_q == LAST_WORD ? DRAIN : ISSUE;
                cnt_d = cnt_q == LAST_WORD ? '0 : cnt_q + 1'b1;
            end
            DRAIN: begin
                state_d = cnt_q == LAST_WAIT ? HOLD : DRAIN;
                cnt_d = cnt_q == LAST_WAIT ? '0 : cnt_q + 1'b1;
            end
            HOLD: state_d = bus.o_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = state_q != IDLE;
    assign bus.bram_en = issue;
    assign bus.bram_addr = issue ? ADDR_WIDTH'(row_q) * ADDR_WIDTH'(WORDS) + ADDR_WIDTH'(cnt_q) : '0;
    assign bus.o_valid = state_q == HOLD;
    assign bus.done = bus.o_valid && bus.o_ready;

    row_gather_lat_pipe #(.DEPTH(READ_LATENCY), .IW(IW)) u_pipe (
        .clk(clk),
        .rst(rst),
        .v_i(issue),
        .idx_i(IW'(cnt_q)),
        .v_o(cap_v),
        .idx_o(cap_idx)
    );

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane[j] = bus.bram_rdata[j*BIT_WIDTH +: BIT_WIDTH];
    end

    // element k lives in lane k%LANES of word k/LANES; untouched elements keep their old value
    for (genvar k = 0; k < N; k++) begin : g_cap
        logic signed [BIT_WIDTH-1:0] data_q;
        always_ff @(posedge clk or posedge rst)
            if (rst) data_q <= '0;
            else if (cap_v && cap_idx == IW'(k / LANES)) data_q <= lane[k % LANES];
        assign bus.o_data[k] = data_q;
    end

`ifdef ROW_GATHER_MAX_EN
    logic signed [BIT_WIDTH-1:0] max_q;
    logic signed [BIT_WIDTH-1:0] run_max [LANES+1];
    assign run_max[0] = max_q;
    for (genvar j = 0; j < LANES; j++) begin : g_max
        assign run_max[j+1] = BIT_WIDTH'(smax(32'(run_max[j]), 32'(lane[j])));
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) max_q <= '0;
        else if (accept) max_q <= {1'b1, {(BIT_WIDTH-1){1'b0}}};
        else if (cap_v) max_q <= run_max[LANES];
    assign bus.o_max = max_q;
`else
    assign bus.o_max = '0;
`endif
endmodule

// File: tb/tb_bram_row_gather.sv
// tb_bram_row_gather: randomized self-checking bench for bram_row_gather (LANES=1/L=1 and LANES=4/L=2 instances)
module tb_bram_row_gather;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bram_row_gather_if #(.BIT_WIDTH(16), .N(32), .LANES(1), .ROW_COUNT(32), .READ_LATENCY(1)) ia ();
    bram_row_gather_if #(.BIT_WIDTH(16), .N(32), .LANES(4), .ROW_COUNT(20), .READ_LATENCY(2)) ib ();

    bram_row_gather #(.BIT_WIDTH(16), .N(32), .LANES(1), .ROW_COUNT(32), .READ_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.master));
    bram_row_gather #(.BIT_WIDTH(16), .N(32), .LANES(4), .ROW_COUNT(20), .READ_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.master));

    // BRAM A: one element per word, one-cycle read. BRAM B: four elements per word, two-cycle read.
    logic signed [15:0] mem_a [1024];
    logic signed [15:0] elem_b [640];
    logic en_b1;
    logic [7:0] addr_b1;
    always @(posedge clk) if (ia.bram_en) ia.bram_rdata <= mem_a[ia.bram_addr];
    always @(posedge clk) begin
        en_b1 <= ib.bram_en;
        addr_b1 <= ib.bram_addr;
        if (en_b1) ib.bram_rdata <= {elem_b[4*int'(addr_b1)+3], elem_b[4*int'(addr_b1)+2],
                                     elem_b[4*int'(addr_b1)+1], elem_b[4*int'(addr_b1)]};
    end

    // reference model: a row is 32 consecutive elements in element order
    function automatic logic signed [15:0] exp_el(input bit sel, input int r, input int k);
        return sel ? elem_b[r*32+k] : mem_a[r*32+k];
    endfunction

    function automatic logic signed [15:0] exp_max(input bit sel, input int r);
`ifdef ROW_GATHER_MAX_EN
        int m = -32768;
        for (int k = 0; k < 32; k++) begin
            int v = int'(exp_el(sel, r, k));
            if (v > m) m = v;
        end
        return 16'(m);
`else
        return 16'sd0;
`endif
    endfunction

    int obs_addr [$];
    int obs_vedge;

    // launches one gather and records issued addresses and the edge at which o_valid rose
    task automatic run(input bit sel, input int row);
        int e;
        obs_addr.delete();
        obs_vedge = -1;
        @(negedge clk);
        if (sel) begin ib.start = 1'b1; ib.row_idx = 5'(row); end
        else begin ia.start = 1'b1; ia.row_idx = 5'(row); end
        @(posedge clk);
        e = 0;
        @(negedge clk);
        ia.start = 1'b0;
        ib.start = 1'b0;
        while (obs_vedge < 0 && e < 100) begin
            if (sel ? ib.bram_en : ia.bram_en) obs_addr.push_back(sel ? int'(ib.bram_addr) : int'(ia.bram_addr));
            if (sel ? ib.o_valid : ia.o_valid) obs_vedge = e;
            else begin
                @(negedge clk);
                e++;
            end
        end
    endtask

    task automatic test_reset();
        int nz = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            if (ia.o_data[k] !== 16'sd0) nz++;
            if (ib.o_data[k] !== 16'sd0) nz++;
        end
        checks++; if (nz != 0) begin failures++; $display("FAIL reset_data nonzero=%0d want 0", nz); end
        checks++; if ({ia.busy, ia.bram_en, ia.o_valid, ia.done} !== 4'b0) begin failures++; $display("FAIL reset_ctl_a got %b want 0000", {ia.busy, ia.bram_en, ia.o_valid, ia.done}); end
        checks++; if ({ib.busy, ib.bram_en, ib.o_valid, ib.done} !== 4'b0) begin failures++; $display("FAIL reset_ctl_b got %b want 0000", {ib.busy, ib.bram_en, ib.o_valid, ib.done}); end
        checks++; if (ia.bram_addr !== 10'd0) begin failures++; $display("FAIL reset_addr_a got %0d want 0", ia.bram_addr); end
        checks++; if (ib.bram_addr !== 8'd0) begin failures++; $display("FAIL reset_addr_b got %0d want 0", ib.bram_addr); end
        checks++; if (ia.o_max !== 16'sd0) begin failures++; $display("FAIL reset_max_a got %0d want 0", ia.o_max); end
        checks++; if (ib.o_max !== 16'sd0) begin failures++; $display("FAIL reset_max_b got %0d want 0", ib.o_max); end
        rst = 1'b0;
    endtask

    // first row uses identity memory contents, later rows random memory and random row indices
    task automatic test_gather(input bit sel);
        int rows [4];
        int w, lat, rc, r;
        w = sel ? 8 : 32;
        lat = sel ? 2 : 1;
        rc = sel ? 20 : 32;
        if (sel) rows = '{1, 27, int'($urandom_range(31)), int'($urandom_range(31))};
        else rows = '{2, int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31))};
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                for (int m = 0; m < 1024; m++) mem_a[m] = 16'($urandom);
                for (int m = 0; m < 640; m++) elem_b[m] = 16'($urandom);
            end
            run(sel, rows[i]);
            r = rows[i] >= rc ? rc - 1 : rows[i];
            checks++; if (obs_addr.size() != w) begin failures++; $display("FAIL en_count sel=%0d got %0d want %0d", sel, obs_addr.size(), w); end
            for (int k = 0; k < obs_addr.size(); k++) begin
                checks++; if (obs_addr[k] != r*w + k) begin failures++; $display("FAIL addr sel=%0d word=%0d got %0d want %0d", sel, k, obs_addr[k], r*w + k); end
            end
            checks++; if (obs_vedge != w + lat) begin failures++; $display("FAIL valid_edge sel=%0d got %0d want %0d", sel, obs_vedge, w + lat); end
            for (int k = 0; k < 32; k++) begin
                checks++; if ((sel ? ib.o_data[k] : ia.o_data[k]) !== exp_el(sel, r, k)) begin failures++; $display("FAIL data sel=%0d row=%0d k=%0d got %0d want %0d", sel, r, k, sel ? ib.o_data[k] : ia.o_data[k], exp_el(sel, r, k)); end
            end
            checks++; if ((sel ? ib.o_max : ia.o_max) !== exp_max(sel, r)) begin failures++; $display("FAIL max sel=%0d got %0d want %0d", sel, sel ? ib.o_max : ia.o_max, exp_max(sel, r)); end
            repeat ($urandom_range(3)) @(negedge clk);
            if (sel) ib.o_ready = 1'b1; else ia.o_ready = 1'b1;
            #1;
            checks++; if ((sel ? ib.done : ia.done) !== 1'b1) begin failures++; $display("FAIL done_pulse sel=%0d got %b want 1", sel, sel ? ib.done : ia.done); end
            @(negedge clk);
            ia.o_ready = 1'b0;
            ib.o_ready = 1'b0;
            #1;
            checks++; if ((sel ? {ib.done, ib.o_valid, ib.busy} : {ia.done, ia.o_valid, ia.busy}) !== 3'b0) begin failures++; $display("FAIL after_done sel=%0d got %b want 000", sel, sel ? {ib.done, ib.o_valid, ib.busy} : {ia.done, ia.o_valid, ia.busy}); end
        end
    endtask

    task automatic test_max();
        logic signed [15:0] head [6] = '{-16'sd5, -16'sd3, 16'sd7, -16'sd32768, 16'sd12, 16'sd0};
        logic signed [15:0] want;
        for (int k = 0; k < 32; k++) mem_a[160+k] = k < 6 ? head[k] : 16'(int'($urandom_range(1011)) - 1000);
`ifdef ROW_GATHER_MAX_EN
        want = 16'sd12;
`else
        want = 16'sd0;
`endif
        run(0, 5);
        checks++; if (ia.o_max !== want) begin failures++; $display("FAIL max_row got %0d want %0d", ia.o_max, want); end
        checks++; if (ia.o_max !== exp_max(0, 5)) begin failures++; $display("FAIL max_model got %0d want %0d", ia.o_max, exp_max(0, 5)); end
        repeat (3) @(negedge clk);
        checks++; if (ia.o_max !== want || ia.o_valid !== 1'b1) begin failures++; $display("FAIL max_stable got %0d valid=%b want %0d valid=1", ia.o_max, ia.o_valid, want); end
        ia.o_ready = 1'b1;
        @(negedge clk);
        ia.o_ready = 1'b0;
    endtask

    task automatic test_stall();
        int r, bad;
        r = $urandom_range(31);
        run(0, r);
        checks++; if (obs_vedge != 33) begin failures++; $display("FAIL stall_valid_edge got %0d want 33", obs_vedge); end
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin ia.start = 1'b1; ia.row_idx = 5'((r + 1) % 32); end
            if (c == 7) ia.start = 1'b0;
            @(negedge clk);
            bad = 0;
            for (int k = 0; k < 32; k++) if (ia.o_data[k] !== exp_el(0, r, k)) bad++;
            checks++; if (ia.o_valid !== 1'b1 || ia.done !== 1'b0 || bad != 0) begin failures++; $display("FAIL stall cycle=%0d valid=%b done=%b bad=%0d want valid=1 done=0 bad=0", c, ia.o_valid, ia.done, bad); end
        end
        ia.o_ready = 1'b1;
        #1;
        checks++; if (ia.done !== 1'b1) begin failures++; $display("FAIL stall_done got %b want 1", ia.done); end
        @(negedge clk);
        ia.o_ready = 1'b0;
        #1;
        checks++; if ({ia.busy, ia.done} !== 2'b0) begin failures++; $display("FAIL stall_release busy,done got %b want 00", {ia.busy, ia.done}); end
    endtask

    task automatic test_back_to_back();
        int x, y, e, bad;
        x = $urandom_range(31);
        y = (x + 7) % 32;
        @(negedge clk);
        ia.start = 1'b1;
        ia.row_idx = 5'(x);
        ia.o_ready = 1'b1;
        @(posedge clk);
        e = 0;
        @(negedge clk);
        ia.row_idx = 5'(y);
        while (ia.done !== 1'b1 && e < 100) begin @(negedge clk); e++; end
        checks++; if (e != 33) begin failures++; $display("FAIL b2b_first_done got edge %0d want 33", e); end
        @(negedge clk);
        checks++; if (ia.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap busy got %b want 0", ia.busy); end
        @(negedge clk);
        checks++; if (ia.busy !== 1'b1 || ia.bram_addr !== 10'(y*32)) begin failures++; $display("FAIL b2b_retrigger busy=%b addr=%0d want busy=1 addr=%0d", ia.busy, ia.bram_addr, y*32); end
        ia.start = 1'b0;
        e = 0;
        while (ia.done !== 1'b1 && e < 100) begin @(negedge clk); e++; end
        checks++; if (e != 33) begin failures++; $display("FAIL b2b_second_done got edge %0d want 33", e); end
        @(negedge clk);
        ia.o_ready = 1'b0;
        bad = 0;
        for (int k = 0; k < 32; k++) if (ia.o_data[k] !== exp_el(0, y, k)) bad++;
        checks++; if (ia.busy !== 1'b0 || bad != 0) begin failures++; $display("FAIL b2b_second_row busy=%b bad=%0d want busy=0 bad=0", ia.busy, bad); end
    endtask

    task automatic test_reset_mid();
        int nz;
        @(negedge clk);
        ia.start = 1'b1;
        ia.row_idx = 5'd3;
        @(posedge clk);
        @(negedge clk);
        ia.start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (ia.bram_en !== 1'b1 || ia.bram_addr !== 10'd106) begin failures++; $display("FAIL mid_word10 en=%b addr=%0d want en=1 addr=106", ia.bram_en, ia.bram_addr); end
        rst = 1'b1;
        #1;
        nz = 0;
        for (int k = 0; k < 32; k++) if (ia.o_data[k] !== 16'sd0) nz++;
        checks++; if ({ia.busy, ia.bram_en, ia.o_valid, ia.done} !== 4'b0 || ia.bram_addr !== 10'd0 || ia.o_max !== 16'sd0 || nz != 0) begin failures++; $display("FAIL mid_reset ctl=%b addr=%0d max=%0d nonzero=%0d want all 0", {ia.busy, ia.bram_en, ia.o_valid, ia.done}, ia.bram_addr, ia.o_max, nz); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        nz = 0;
        for (int k = 0; k < 32; k++) if (ia.o_data[k] !== 16'sd0) nz++;
        checks++; if (nz != 0 || ia.busy !== 1'b0) begin failures++; $display("FAIL mid_stale nonzero=%0d busy=%b want 0 0", nz, ia.busy); end
        run(0, 0);
        checks++; if (obs_vedge != 33 || obs_addr.size() != 32) begin failures++; $display("FAIL mid_restart edge=%0d en=%0d want 33 32", obs_vedge, obs_addr.size()); end
        for (int k = 0; k < 32; k++) begin
            checks++; if (ia.o_data[k] !== exp_el(0, 0, k)) begin failures++; $display("FAIL mid_data k=%0d got %0d want %0d", k, ia.o_data[k], exp_el(0, 0, k)); end
        end
        ia.o_ready = 1'b1;
        @(negedge clk);
        ia.o_ready = 1'b0;
    endtask

    initial begin
        ia.start = 1'b0;
        ia.row_idx = '0;
        ia.o_ready = 1'b0;
        ib.start = 1'b0;
        ib.row_idx = '0;
        ib.o_ready = 1'b0;
        for (int m = 0; m < 1024; m++) mem_a[m] = 16'(m);
        for (int m = 0; m < 640; m++) elem_b[m] = 16'(m);
        test_reset();
        test_gather(1'b0);
        test_gather(1'b1);
        test_max();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
